// File: rtl/cla_nibble_seq_adder_if.sv
// Start/busy/done handshake bundle for the nibble-serial CLA adder.
// The master side issues operands and start; the slave side returns status and result.
interface cla_nibble_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   sum;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, ovf
    );
endinterface

// File: rtl/cla_nibble_seq_adder.sv
// Multi-cycle WIDTH-bit adder built from one 4-bit carry-lookahead slice.
// Operands are latched on an accepted start and summed one nibble per cycle,
// LSB nibble first, with a registered carry linking consecutive nibbles.
module cla_nibble_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    cla_nibble_seq_adder_if.slave  bus
);
    localparam int NNIB  = WIDTH / 4;
    localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;
    logic [WIDTH:0]   sum_reg;
    logic             ovf_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_s;
    logic             c3;
    logic             c4;
    logic             last;

    // 4-bit carry-lookahead slice; returns {c4, c3, s[3:0]}.
    // c3 is kept so the caller can form signed overflow as c3^c4.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic c0);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], c[3], p ^ c[3:0]};
    endfunction

    // Select the current nibble of each latched operand and run it through the slice.
    always_comb begin
        nib_a = a_reg[4*int'(idx) +: 4];
        nib_b = b_reg[4*int'(idx) +: 4];
        {c4, c3, nib_s} = cla4(nib_a, nib_b, carry_reg);
        last = (idx == IDX_W'(NNIB - 1));
    end

    // Next-state logic: IDLE waits for start, RUN walks the nibbles, DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus registered busy/done status derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            busy_reg <= (state_next == RUN);
            done_reg <= (state_next == DONE);
        end
    end

    // Operand latch on accepted start; one nibble of sum and the carry link per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg   <= '0;
            ovf_reg   <= 1'b0;
            idx       <= '0;
            carry_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        carry_reg <= bus.cin;
                        idx       <= '0;
                        sum_reg   <= '0;
                        ovf_reg   <= 1'b0;
                    end
                end
                RUN: begin
                    sum_reg[4*int'(idx) +: 4] <= nib_s;
                    carry_reg                 <= c4;
                    if (last) begin
                        sum_reg[WIDTH] <= c4;
                        ovf_reg        <= c3 ^ c4;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.sum  = sum_reg;
    assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Bench for cla_nibble_seq_adder: a 16-bit instance exercised with directed and random
// vectors plus a start-every-cycle burst, and a 4-bit instance for the single-nibble case.
module tb_cla_nibble_seq_adder;
    localparam int W16  = 16;
    localparam int NN16 = W16 / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cla_nibble_seq_adder_if #(.WIDTH(W16)) bus16 ();
    cla_nibble_seq_adder_if #(.WIDTH(4))   bus4  ();

    cla_nibble_seq_adder #(.WIDTH(W16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    cla_nibble_seq_adder #(.WIDTH(4))   dut4  (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned addition for {carry, sum}.
    function automatic logic [16:0] ref_sum16(input logic [15:0] a, input logic [15:0] b,
                                              input logic cin);
        return {1'b0, a} + {1'b0, b} + {16'd0, cin};
    endfunction

    // Reference: signed overflow means the true signed result leaves the 16-bit range.
    function automatic logic ref_ovf16(input logic [15:0] a, input logic [15:0] b,
                                       input logic cin);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(cin);
        return (s > 32767) || (s < -32768);
    endfunction

    // Issue one 16-bit operation, scramble the inputs afterwards, and check
    // latency, result and overflow. Ends with the unit back in IDLE.
    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [16:0] exp_sum, input logic exp_ovf,
                        output int busy_cnt);
        int lat;
        bus16.start = 1'b1;
        bus16.a     = a;
        bus16.b     = b;
        bus16.cin   = cin;
        @(negedge clk);
        bus16.start = 1'b0;
        bus16.a     = 16'($urandom);
        bus16.b     = 16'($urandom);
        bus16.cin   = 1'($urandom);
        lat      = 0;
        busy_cnt = 0;
        while (!bus16.done && lat < 20) begin
            if (bus16.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(NN16));
        check({tag, "_sum"}, 32'(bus16.sum), 32'(exp_sum));
        check({tag, "_ovf"}, 32'(bus16.ovf), 32'(exp_ovf));
        @(negedge clk);
    endtask

    initial begin
        int bc;
        int next_free;
        int done_at;
        int accepts;
        int dones;
        logic [15:0] ta, tb_b;
        logic        tc;
        logic [15:0] qa, qb;
        logic        qc;

        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
        bus4.start  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0;
        qa = '0; qb = '0; qc = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(bus16.busy), 32'd0);
        check("rst_done", 32'(bus16.done), 32'd0);
        check("rst_sum",  32'(bus16.sum),  32'd0);
        check("rst_ovf",  32'(bus16.ovf),  32'd0);
        check("rst_sum4", 32'(bus4.sum),   32'd0);
        @(negedge clk);

        // Directed vectors with hand-computed results
        op16("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 17'h1_0000, 1'b0, bc);
        check("ffff_busy_cycles", 32'(bc), 32'd4);
        repeat (3) @(negedge clk);
        check("ffff_sum_hold", 32'(bus16.sum), 32'h1_0000);
        op16("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 17'h0_8000, 1'b1, bc);
        op16("8000_8000", 16'h8000, 16'h8000, 1'b0, 17'h1_0000, 1'b1, bc);
        op16("zero_cin", 16'h0000, 16'h0000, 1'b1, 17'h0_0001, 1'b0, bc);
        op16("ffff_ffff_cin", 16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF, 1'b0, bc);

        // Random vectors against the arithmetic model
        for (int i = 0; i < 1000; i++) begin
            ta   = 16'($urandom);
            tb_b = 16'($urandom);
            tc   = 1'($urandom);
            op16("rand", ta, tb_b, tc, ref_sum16(ta, tb_b, tc), ref_ovf16(ta, tb_b, tc), bc);
        end

        // Start held every cycle: the unit is free again NNIB+2 cycles after acceptance
        next_free = 0;
        done_at   = -1;
        accepts   = 0;
        dones     = 0;
        for (int i = 0; i < 32; i++) begin
            bus16.start = (i < 20);
            bus16.a     = 16'($urandom);
            bus16.b     = 16'($urandom);
            bus16.cin   = 1'($urandom);
            if (bus16.start && i >= next_free) begin
                qa        = bus16.a;
                qb        = bus16.b;
                qc        = bus16.cin;
                done_at   = i + NN16;
                next_free = i + NN16 + 2;
                accepts++;
            end
            @(negedge clk);
            check("burst_done", 32'(bus16.done), 32'(i == done_at));
            if (bus16.done) dones++;
            if (i == done_at) begin
                check("burst_sum", 32'(bus16.sum), 32'(ref_sum16(qa, qb, qc)));
                check("burst_ovf", 32'(bus16.ovf), 32'(ref_ovf16(qa, qb, qc)));
            end
        end
        bus16.start = 1'b0;
        check("burst_accepts", 32'(accepts), 32'd4);
        check("burst_dones", 32'(dones), 32'd4);

        // Single-nibble build: RUN lasts one cycle
        bus4.start = 1'b1; bus4.a = 4'h9; bus4.b = 4'h8; bus4.cin = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0; bus4.cin = 1'b0;
        check("w4_busy", 32'(bus4.busy), 32'd1);
        check("w4_done_early", 32'(bus4.done), 32'd0);
        @(negedge clk);
        check("w4_done", 32'(bus4.done), 32'd1);
        check("w4_sum", 32'(bus4.sum), 32'h12);
        check("w4_ovf", 32'(bus4.ovf), 32'd1);
        @(negedge clk);
        check("w4_done_pulse", 32'(bus4.done), 32'd0);

        // Reset two cycles into RUN aborts without a done pulse
        bus16.start = 1'b1; bus16.a = 16'h1234; bus16.b = 16'h4321; bus16.cin = 1'b0;
        @(negedge clk);
        bus16.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus16.busy), 32'd0);
        check("abort_sum",  32'(bus16.sum),  32'd0);
        check("abort_ovf",  32'(bus16.ovf),  32'd0);
        check("abort_sum4", 32'(bus4.sum),   32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus16.done) dones++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(dones), 32'd0);
        op16("after_abort", 16'hA5A5, 16'h5A5B, 1'b0, 17'h1_0000, 1'b0, bc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
